lifting_dwt_1d: RTL and testbench
=================================

# lifting_dwt_1d

Streaming, parametrised 1-D integer lifting wavelet stage for the image-squash datapath. It pairs consecutive samples (even, odd) and computes one low-pass (L) and one high-pass (H) coefficient per pair in forward mode, or reconstructs the sample pair from an (L, H) stream in inverse mode. It uses valid/ready handshakes on both sides and frames each image line of LINE_LEN samples. It is the successor to the fixed 8-bit, free-running shift-based lifting test stage and sits between the pixel source and the coefficient quantiser/packer.

## Interface
- DATA_W, 8, sample width (unsigned pixels); coefficients are DATA_W+1 bits two's complement
- LINE_LEN, 16, samples per line; even, >= 2
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- mode  in  1  0 = forward, 1 = inverse; sampled only at line start
- s_valid  in  1  input word valid
- s_ready  out  1  input word accepted when s_valid && s_ready
- s_data  in  DATA_W+1  forward: bits [DATA_W-1:0] = unsigned sample, MSB ignored; inverse: alternating L (zero-extended), then H (signed)
- m_valid  out  1  output pair valid
- m_ready  in  1  output pair consumed when m_valid && m_ready
- m_data0  out  DATA_W+1  forward: L zero-extended; inverse: even sample
- m_data1  out  DATA_W+1  forward: H signed; inverse: odd sample (low DATA_W bits meaningful)
- m_last  out  1  marks the final pair of a line (pair index LINE_LEN/2-1)

## Operation
- Phase FSM:
  - FIRST: waiting for the even sample (forward) or L (inverse).
  - SECOND: first word held in hold_reg, waiting for its partner.
- FIRST -> SECOND on accept. SECOND -> FIRST on accept; the pair result loads into the output register.
- Forward arithmetic, all at DATA_W+2 bits signed, results truncated to DATA_W+1:
  - H = o - e
  - L = e + (H >>> 1), which equals floor((e+o)/2) and always fits in DATA_W bits
- Inverse arithmetic:
  - e = L - (H >>> 1)
  - o = H + e
  - Results are truncated to DATA_W+1 bits, two's-complement wrap; no saturation. Inverse of any valid forward output is exact.
- `>>>` is an arithmetic shift, so it rounds toward negative infinity.
- Mode latching:
  - mode is latched into mode_q when the first word of pair index 0 is accepted.
  - Changes to mode mid-line are ignored until the next line.
- Line framing:
  - Pair counter runs 0..LINE_LEN/2-1 and increments when a pair is loaded into the output register.
  - It wraps to 0 after the last pair. m_last = (pair index of the registered pair == LINE_LEN/2-1).
- Output register (single entry):
  - Holds m_data0/m_data1/m_last until m_valid && m_ready.
- Flow control:
  - s_ready = !(phase == SECOND && m_valid && !m_ready).
  - The first word is always accepted while in FIRST, so input and output stall independently.

## Timing
- Reset values: m_valid=0, m_data0=0, m_data1=0, m_last=0, s_ready=1, phase=FIRST, pair counter=0, mode_q=0, hold_reg=0.
- Latency: m_valid rises the cycle after the second word of a pair is accepted.
- Throughput: one pair per 2 cycles with both sides always ready. No bubble when m_ready is held high.
- Simultaneous events: when m_ready pops the current pair in the same cycle a second word is accepted, the new pair replaces it and m_valid stays 1.
- Backpressure: with m_valid=1 and m_ready=0:
  - The first word of the next pair is still accepted.
  - s_ready drops in SECOND until the output drains.
  - m_data0/m_data1/m_last must stay stable while stalled.
- Reset mid-line: discards hold_reg and any pending output the same cycle. The next accepted word is treated as the even word of pair 0 and mode is re-latched.
- LINE_LEN=2: every pair asserts m_last.

## Test plan
- Forward, DATA_W=8, line 0x22,0x44,0x50,0x70,0x86,0x54,... with m_ready=1:
  - pair 0 -> L=0x033, H=0x022
  - pair 1 -> L=0x060, H=0x020
  - pair 2 -> L=0x06D, H=0x1CE (-50)
  - m_valid exactly 1 cycle after each odd accept
- Extremes: e=0xFF, o=0x00 -> H=0x101 (-255), L=0x07F. e=0x00, o=0xFF -> H=0x0FF, L=0x07F.
- Inverse: stream L=0x06D, H=0x1CE -> m_data0=0x086, m_data1=0x054.
- Round trip: random LINE_LEN=16 lines, forward output fed to an inverse instance, reconstructs input bit-exactly.
- Backpressure: hold m_ready=0 for 5 cycles after the first pair.
  - Next even word is accepted, then s_ready=0 in SECOND.
  - Outputs stay stable; no data lost or duplicated.
  - m_last is asserted on pair 7 of every 16-sample line.
- Mid-stream:
  - Toggling mode mid-line has no effect until the next line.
  - Asserting rst after 3 words gives m_valid=0 the next cycle. The next line restarts at pair 0, producing correct L/H and m_last on its 8th pair.

Source files
------------

// File: rtl/lifting_dwt_1d.sv
// -----------------------------------------------------------------------------
// lifting_dwt_1d
//
// Streaming 1-D integer lifting wavelet stage. Consecutive words are paired
// (even, odd). Forward mode turns each sample pair into one low-pass (L) and
// one high-pass (H) coefficient. Inverse mode turns each (L, H) pair back
// into the (even, odd) sample pair. Both sides use valid/ready handshakes.
// Output pairs are framed into lines of LINE_LEN input words.
//
// Parameters
//   DATA_W   : unsigned sample width; coefficients are DATA_W+1 bits signed
//   LINE_LEN : words per line (even, >= 2)
//
// Ports
//   clk, rst : rising-edge clock, synchronous active-high reset
//   mode     : 0 = forward, 1 = inverse; latched on the first word of a line
//   s_valid / s_ready / s_data   : input word stream
//   m_valid / m_ready            : output pair handshake
//   m_data0  : forward L (zero-extended) / inverse even sample
//   m_data1  : forward H (signed)        / inverse odd sample
//   m_last   : final pair of a line
// -----------------------------------------------------------------------------
module lifting_dwt_1d #(
  parameter int DATA_W   = 8,
  parameter int LINE_LEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W:0]   s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W:0]   m_data0,
  output logic [DATA_W:0]   m_data1,
  output logic              m_last
);

  typedef enum logic {
    PH_FIRST  = 1'b0,  // waiting for even sample / L
    PH_SECOND = 1'b1   // first word held, waiting for its partner
  } phase_t;

  localparam int NUM_PAIRS = LINE_LEN / 2;
  localparam int CNT_W     = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(NUM_PAIRS - 1);

  phase_t            phase_q,   phase_d;
  logic [DATA_W:0]   hold_q,    hold_d;
  logic              mode_q,    mode_d;
  logic [CNT_W-1:0]  pair_q,    pair_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W:0]   m_data0_q, m_data0_d;
  logic [DATA_W:0]   m_data1_q, m_data1_d;
  logic              m_last_q,  m_last_d;

  logic s_accept;
  logic pair_done;
  logic out_pop;

  // Lifting arithmetic, evaluated at DATA_W+2 bits signed.
  logic signed [DATA_W+1:0] fwd_e, fwd_o, fwd_h;
  logic signed [DATA_W+1:0] inv_l, inv_h, inv_e;
  logic        [DATA_W:0]   res0, res1;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the held word and the output data registers are reset too, since
      // their zero state is observable on m_data0/m_data1 right after reset.
      phase_q   <= PH_FIRST;
      hold_q    <= '0;
      mode_q    <= 1'b0;
      pair_q    <= '0;
      m_valid_q <= 1'b0;
      m_data0_q <= '0;
      m_data1_q <= '0;
      m_last_q  <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      hold_q    <= hold_d;
      mode_q    <= mode_d;
      pair_q    <= pair_d;
      m_valid_q <= m_valid_d;
      m_data0_q <= m_data0_d;
      m_data1_q <= m_data1_d;
      m_last_q  <= m_last_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic for the phase FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves
    // a signal unassigned would otherwise infer a latch.
    phase_d = phase_q;
    if (s_accept) begin
      phase_d = (phase_q == PH_FIRST) ? PH_SECOND : PH_FIRST;
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  // Only the second word needs a free output slot. The first word is always
  // taken, so input and output can stall independently.
  always_comb begin
    s_ready = !((phase_q == PH_SECOND) && m_valid_q && !m_ready);
  end

  assign m_valid = m_valid_q;
  assign m_data0 = m_data0_q;
  assign m_data1 = m_data1_q;
  assign m_last  = m_last_q;

  assign s_accept  = s_valid && s_ready;
  assign pair_done = s_accept && (phase_q == PH_SECOND);
  assign out_pop   = m_valid_q && m_ready;

  // ---------------------------------------------------------------------------
  // Lifting datapath: hold_q is the first word, s_data the second.
  // ---------------------------------------------------------------------------
  always_comb begin
    // Forward: the MSB of each input word is ignored; samples are unsigned.
    fwd_e = $signed({2'b00, hold_q[DATA_W-1:0]});
    fwd_o = $signed({2'b00, s_data[DATA_W-1:0]});
    fwd_h = fwd_o - fwd_e;

    // Inverse: L arrives zero-extended and H arrives signed.
    inv_l = $signed({1'b0, hold_q});
    inv_h = $signed({s_data[DATA_W], s_data});
    inv_e = inv_l - (inv_h >>> 1);

    if (mode_q) begin
      res0 = inv_e[DATA_W:0];
      res1 = (DATA_W+1)'(inv_h + inv_e);
    end else begin
      // The arithmetic shift floors, so L = floor((e + o) / 2).
      res0 = (DATA_W+1)'(fwd_e + (fwd_h >>> 1));
      res1 = fwd_h[DATA_W:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Hold register, mode latch, pair counter and output register
  // ---------------------------------------------------------------------------
  always_comb begin
    hold_d    = hold_q;
    mode_d    = mode_q;
    pair_d    = pair_q;
    m_valid_d = m_valid_q;
    m_data0_d = m_data0_q;
    m_data1_d = m_data1_q;
    m_last_d  = m_last_q;

    if (s_accept && (phase_q == PH_FIRST)) begin
      hold_d = s_data;
      // The mode is fixed for the whole line by its first word.
      if (pair_q == '0) begin
        mode_d = mode;
      end
    end

    // A new pair loads over a pair that is popped in the same cycle, so
    // m_valid stays high with no bubble.
    if (pair_done) begin
      m_valid_d = 1'b1;
      m_data0_d = res0;
      m_data1_d = res1;
      m_last_d  = (pair_q == LAST_PAIR);
      pair_d    = (pair_q == LAST_PAIR) ? '0 : pair_q + CNT_W'(1);
    end else if (out_pop) begin
      m_valid_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_lifting_dwt_1d.sv
// -----------------------------------------------------------------------------
// tb_lifting_dwt_1d
//
// Self-checking bench for lifting_dwt_1d. It combines three kinds of test.
// A table of single-pair vectors covers the worked examples and the extreme
// sample values. Random lines run with random valid/ready gaps and are checked
// against an arithmetic reference model. Hand-written sequences cover
// backpressure, reset in the middle of a line, and LINE_LEN=2.
// -----------------------------------------------------------------------------
module tb_lifting_dwt_1d;

  localparam int DW = 8;
  localparam int LL = 16;
  localparam int NP = LL / 2;
  localparam int BUDGET = 2000;

  logic          clk;
  logic          rst;
  logic          mode;
  logic          s_valid;
  logic          s_ready;
  logic [DW:0]   s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW:0]   m_data0;
  logic [DW:0]   m_data1;
  logic          m_last;

  // Second instance with the shortest legal line
  logic          mode2;
  logic          s2_valid;
  logic          s2_ready;
  logic [DW:0]   s2_data;
  logic          m2_valid;
  logic          m2_ready;
  logic [DW:0]   m2_data0;
  logic [DW:0]   m2_data1;
  logic          m2_last;

  int n_tests = 0;
  int n_fail  = 0;

  int line_in [LL];
  int orig    [LL];
  int exp0    [NP];
  int exp1    [NP];
  int out0    [NP];
  int out1    [NP];
  int drv_cycles;

  typedef struct {
    logic  md;
    int    w0;
    int    w1;
    int    e0;
    int    e1;
    string name;
  } vec_t;

  vec_t vecs [7];

  lifting_dwt_1d #(.DATA_W(DW), .LINE_LEN(LL)) dut (
    .clk     (clk),
    .rst     (rst),
    .mode    (mode),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data0 (m_data0),
    .m_data1 (m_data1),
    .m_last  (m_last)
  );

  lifting_dwt_1d #(.DATA_W(DW), .LINE_LEN(2)) dut2 (
    .clk     (clk),
    .rst     (rst),
    .mode    (mode2),
    .s_valid (s2_valid),
    .s_ready (s2_ready),
    .s_data  (s2_data),
    .m_valid (m2_valid),
    .m_ready (m2_ready),
    .m_data0 (m2_data0),
    .m_data1 (m2_data1),
    .m_last  (m2_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: plain integer arithmetic on the lifting equations
  // ---------------------------------------------------------------------------
  function automatic int floor_half(input int x);
    return (x >= 0) ? x / 2 : -((1 - x) / 2);
  endfunction

  function automatic int ref_fwd_l(input int w0, input int w1);
    return ((w0 & 255) + (w1 & 255)) / 2;
  endfunction

  function automatic int ref_fwd_h(input int w0, input int w1);
    return ((w1 & 255) - (w0 & 255)) & 'h1FF;
  endfunction

  function automatic int to_signed9(input int v);
    return ((v & 'h100) != 0) ? (v & 'h1FF) - 512 : (v & 'h1FF);
  endfunction

  function automatic int ref_inv_e(input int l, input int h);
    return ((l & 'h1FF) - floor_half(to_signed9(h))) & 'h1FF;
  endfunction

  function automatic int ref_inv_o(input int l, input int h);
    int e;
    e = (l & 'h1FF) - floor_half(to_signed9(h));
    return (to_signed9(h) + e) & 'h1FF;
  endfunction

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    s_valid  = 1'b0;
    s_data   = '0;
    m_ready  = 1'b1;
    s2_valid = 1'b0;
    m2_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Send one pair right after a reset and check the one-cycle latency.
  task automatic apply_pair(input vec_t v);
    do_reset();
    mode    = v.md;
    s_valid = 1'b1;
    s_data  = 9'(v.w0);
    @(negedge clk);
    check({v.name, "_valid_early"}, 32'(m_valid), 32'd0);
    s_data = 9'(v.w1);
    @(negedge clk);
    s_valid = 1'b0;
    check({v.name, "_valid"}, 32'(m_valid), 32'd1);
    check({v.name, "_d0"}, 32'(m_data0), 32'(v.e0));
    check({v.name, "_d1"}, 32'(m_data1), 32'(v.e1));
    check({v.name, "_last"}, 32'(m_last), 32'd0);
    @(negedge clk);
    check({v.name, "_valid_drop"}, 32'(m_valid), 32'd0);
  endtask

  // Stream line_in through the DUT with random idle/stall percentages. The
  // mode input is randomised after the first word to show it is ignored.
  task automatic run_line(input logic md, input int vidle, input int rstall);
    for (int p = 0; p < NP; p++) begin
      if (md == 1'b0) begin
        exp0[p] = ref_fwd_l(line_in[2*p], line_in[2*p+1]);
        exp1[p] = ref_fwd_h(line_in[2*p], line_in[2*p+1]);
      end else begin
        exp0[p] = ref_inv_e(line_in[2*p], line_in[2*p+1]);
        exp1[p] = ref_inv_o(line_in[2*p], line_in[2*p+1]);
      end
    end
    fork
      begin : driver
        int i;
        i = 0;
        drv_cycles = 0;
        while (i < LL && drv_cycles < BUDGET) begin
          @(negedge clk);
          drv_cycles++;
          s_valid = (vidle == 0) || ($urandom_range(0, 99) >= 32'(vidle));
          s_data  = 9'(line_in[i]);
          mode    = (i == 0) ? md : 1'($urandom_range(0, 1));
          #1;
          if (s_valid && s_ready) i++;
        end
        if (i < LL) check("drv_timeout", 32'(i), 32'(LL));
        @(negedge clk);
        s_valid = 1'b0;
      end
      begin : monitor
        int n;
        int cyc;
        logic stall;
        logic [DW:0] h0;
        logic [DW:0] h1;
        logic hl;
        n = 0;
        cyc = 0;
        stall = 1'b0;
        h0 = '0;
        h1 = '0;
        hl = 1'b0;
        while (n < NP && cyc < BUDGET) begin
          @(negedge clk);
          cyc++;
          if (stall) check("stall_stable", {m_valid, m_data0, m_data1, m_last}, {1'b1, h0, h1, hl});
          m_ready = (rstall == 0) || ($urandom_range(0, 99) >= 32'(rstall));
          if (m_valid && m_ready) begin
            check("pair_d0", 32'(m_data0), 32'(exp0[n]));
            check("pair_d1", 32'(m_data1), 32'(exp1[n]));
            check("pair_last", 32'(m_last), 32'(n == NP - 1));
            out0[n] = int'(m_data0);
            out1[n] = int'(m_data1);
            n++;
            stall = 1'b0;
          end else begin
            stall = m_valid;
            h0 = m_data0;
            h1 = m_data1;
            hl = m_last;
          end
        end
        if (n < NP) check("mon_timeout", 32'(n), 32'(NP));
      end
    join
    m_ready = 1'b1;
    @(negedge clk);
    check("no_extra_pair", 32'(m_valid), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    vecs[0] = '{1'b0, 'h022, 'h044, 'h033, 'h022, "fwd_p0"};
    vecs[1] = '{1'b0, 'h050, 'h070, 'h060, 'h020, "fwd_p1"};
    vecs[2] = '{1'b0, 'h086, 'h054, 'h06D, 'h1CE, "fwd_p2"};
    vecs[3] = '{1'b0, 'h0FF, 'h000, 'h07F, 'h101, "fwd_ff_00"};
    vecs[4] = '{1'b0, 'h000, 'h0FF, 'h07F, 'h0FF, "fwd_00_ff"};
    vecs[5] = '{1'b0, 'h1FF, 'h100, 'h07F, 'h101, "fwd_msb_ignored"};
    vecs[6] = '{1'b1, 'h06D, 'h1CE, 'h086, 'h054, "inv_p2"};

    rst      = 1'b1;
    mode     = 1'b0;
    s_valid  = 1'b0;
    s_data   = '0;
    m_ready  = 1'b1;
    mode2    = 1'b0;
    s2_valid = 1'b0;
    s2_data  = '0;
    m2_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    do_reset();
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data0", 32'(m_data0), 32'd0);
    check("rst_m_data1", 32'(m_data1), 32'd0);
    check("rst_m_last",  32'(m_last),  32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);

    // Table-driven single pairs
    for (int k = 0; k < 7; k++) apply_pair(vecs[k]);

    // Worked-example line at full rate: no bubble, 16 words in 16 cycles
    do_reset();
    line_in[0] = 'h22; line_in[1] = 'h44; line_in[2] = 'h50;
    line_in[3] = 'h70; line_in[4] = 'h86; line_in[5] = 'h54;
    for (int i = 6; i < LL; i++) line_in[i] = int'($urandom_range(0, 255));
    run_line(1'b0, 0, 0);
    check("full_rate_cycles", 32'(drv_cycles), 32'(LL));

    // Round trip over several lines with random gaps and stalls
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < LL; i++) begin
        orig[i]    = int'($urandom_range(0, 511));
        line_in[i] = orig[i];
      end
      run_line(1'b0, 30, 30);
      for (int p = 0; p < NP; p++) begin
        line_in[2*p]   = out0[p];
        line_in[2*p+1] = out1[p];
      end
      run_line(1'b1, 30, 30);
      for (int p = 0; p < NP; p++) begin
        check("roundtrip_even", 32'(out0[p]), 32'(orig[2*p] & 255));
        check("roundtrip_odd",  32'(out1[p]), 32'(orig[2*p+1] & 255));
      end
    end

    // Backpressure: stall the output for 5 cycles after the first pair
    do_reset();
    mode    = 1'b0;
    s_valid = 1'b1;
    s_data  = 9'h022;
    @(negedge clk);
    s_data = 9'h044;
    @(negedge clk);
    check("bp_first_valid", 32'(m_valid), 32'd1);
    m_ready = 1'b0;
    s_data  = 9'h050;
    #1;
    check("bp_even_ready", 32'(s_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      s_data = 9'h070;
      #1;
      check("bp_second_blocked", 32'(s_ready), 32'd0);
      check("bp_hold_data", {23'd0, m_valid, m_data0, m_data1}, {23'd0, 1'b1, 9'h033, 9'h022});
    end
    @(negedge clk);
    m_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
    check("bp_replace_valid", 32'(m_valid), 32'd1);
    check("bp_replace_d0", 32'(m_data0), 32'h060);
    check("bp_replace_d1", 32'(m_data1), 32'h020);
    @(negedge clk);
    check("bp_drained", 32'(m_valid), 32'd0);

    // Reset after 3 words with a pending output, then an inverse line
    do_reset();
    mode    = 1'b0;
    s_valid = 1'b1;
    s_data  = 9'h010;
    @(negedge clk);
    s_data = 9'h020;
    @(negedge clk);
    m_ready = 1'b0;
    s_data  = 9'h030;
    @(negedge clk);
    rst     = 1'b1;
    s_valid = 1'b0;
    check("mid_pending", 32'(m_valid), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid", 32'(m_valid), 32'd0);
    check("mid_rst_ready", 32'(s_ready), 32'd1);
    for (int p = 0; p < NP; p++) begin
      line_in[2*p]   = int'($urandom_range(0, 255));
      line_in[2*p+1] = int'($urandom_range(0, 511));
    end
    run_line(1'b1, 20, 20);

    // LINE_LEN = 2: every pair is the last pair of its line
    do_reset();
    mode2    = 1'b0;
    s2_valid = 1'b1;
    for (int p = 0; p < 3; p++) begin
      int a;
      int b;
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      s2_data = 9'(a);
      @(negedge clk);
      s2_data = 9'(b);
      @(negedge clk);
      check("ll2_valid", 32'(m2_valid), 32'd1);
      check("ll2_last",  32'(m2_last),  32'd1);
      check("ll2_d0", 32'(m2_data0), 32'(ref_fwd_l(a, b)));
      check("ll2_d1", 32'(m2_data1), 32'(ref_fwd_h(a, b)));
    end
    s2_valid = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
